// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_pkg
//  Purpose  : Shared types and constants for the instruction fetch unit.
//             - state_t          : fetch FSM state encoding
//             - INST_NOP         : instruction presented before the first fetch
//             - DEFAULT_RESET_PC : default first fetch address
//  Revision : 1.0  initial release
// ============================================================================
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // request slot: drive imem_req_valid
        S_WAIT = 2'd1,   // one request outstanding, waiting for its response
        S_HOLD = 2'd2    // instruction presented to decode, waiting for ready
    } state_t;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage : ifu_fetch_pkg
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch
//  Purpose  : Instruction fetch unit. Holds the fetch PC, issues one word read
//             at a time to instruction memory, and presents inst/pc/snpc to
//             decode under a valid/ready handshake. A redirect from execute
//             replaces the fetch PC and squashes any wrong-path response.
//
//  Ports    :
//    clock           in   system clock
//    reset           in   asynchronous active-high reset
//    redirect_valid  in   execute requests a PC change this cycle
//    redirect_pc     in   new fetch address (low two bits ignored)
//    imem_req_valid  out  fetch request valid
//    imem_req_ready  in   memory accepts the request
//    imem_addr       out  word-aligned fetch address
//    imem_rsp_valid  in   read data valid (one per accepted request, in order)
//    imem_rsp_data   in   instruction word
//    inst            out  instruction to decode
//    pc              out  address of inst
//    snpc            out  pc + 4
//    valid_next      out  inst/pc/snpc valid
//    ready_next      in   decode can accept
//
//  Revision : 1.0  initial release
// ============================================================================
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] snpc,
    output logic            valid_next,
    input  logic            ready_next
);

    localparam logic [XLEN-1:0] C_WORD      = XLEN'(4);
    localparam logic [XLEN-1:0] C_ALIGN     = ~XLEN'(3);
    localparam logic [XLEN-1:0] C_RESET_NPC = RESET_PC + C_WORD;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_drop;       // the outstanding response is wrong-path
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_snpc;
    logic            r_valid;

    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_fetch_npc;

    assign w_redirect_pc = redirect_pc & C_ALIGN;
    assign w_fetch_npc   = r_fetch_pc + C_WORD;   // wraps mod 2^XLEN

    // The reset state is S_REQ, yet no request may be issued while reset is
    // held, so the request strobe is also qualified by reset itself.
    assign imem_req_valid = (r_state == S_REQ) && !reset;
    assign imem_addr      = r_fetch_pc;
    assign inst           = r_inst;
    assign pc             = r_pc;
    assign snpc           = r_snpc;
    assign valid_next     = r_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
            r_inst     <= XLEN'(INST_NOP);
            r_pc       <= RESET_PC;
            r_snpc     <= C_RESET_NPC;
            r_valid    <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over every other event: new PC, nothing presented.
            r_fetch_pc <= w_redirect_pc;
            r_valid    <= 1'b0;
            case (r_state)
                S_REQ: begin
                    // A request accepted in the same cycle is already on the
                    // wrong path; mark its response for discard.
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Decode squashes a same-cycle handshake on its own side.
                    r_state <= S_REQ;
                end
                default: begin
                    r_state <= S_REQ;
                    r_drop  <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst     <= imem_rsp_data;
                            r_pc       <= r_fetch_pc;
                            r_snpc     <= w_fetch_npc;
                            r_fetch_pc <= w_fetch_npc;
                            r_valid    <= 1'b1;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // inst/pc/snpc are untouched here, so they stay stable
                    // for as long as decode stalls.
                    if (r_valid && ready_next) begin
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                    r_drop  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : ifu_fetch
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu_fetch
//  Purpose  : Directed self-checking bench for ifu_fetch. The main instance
//             uses the default reset PC; a second instance starts at
//             32'hFFFF_FFFC to exercise address wrap-around.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifu_fetch;

    logic        clock;
    logic        reset;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        valid_next;
    logic        ready_next;

    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [31:0] w_snpc;
    logic        w_valid;
    logic        w_ready;

    int n_checks;
    int n_errors;

    ifu_fetch u_dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .pc             (pc),
        .snpc           (snpc),
        .valid_next     (valid_next),
        .ready_next     (ready_next)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_addr      (w_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .inst           (w_inst),
        .pc             (w_pc),
        .snpc           (w_snpc),
        .valid_next     (w_valid),
        .ready_next     (w_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a fresh fetch from S_REQ with zero-wait memory; ends in S_HOLD.
    task automatic fetch_one(input logic [31:0] data);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_checks++; if (valid_next !== 1'b0) begin n_errors++; $display("FAIL reset_valid_next: got %b want 0", valid_next); end
        n_checks++; if (inst !== 32'h0000_0013) begin n_errors++; $display("FAIL reset_inst: got %h want 00000013", inst); end
        n_checks++; if ({pc, snpc} !== {32'h8000_0000, 32'h8000_0004}) begin n_errors++; $display("FAIL reset_pc_snpc: got %h/%h want 80000000/80000004", pc, snpc); end
        reset = 1'b0;
        #1;
        n_checks++; if ({imem_req_valid, imem_addr} !== {1'b1, 32'h8000_0000}) begin n_errors++; $display("FAIL release_req: got %b/%h want 1/80000000", imem_req_valid, imem_addr); end
    endtask

    task automatic test_basic();
        ready_next = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        n_checks++; if ({imem_req_valid, valid_next} !== 2'b00) begin n_errors++; $display("FAIL basic_wait: got req=%b valid=%b want 0/0", imem_req_valid, valid_next); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        tick();
        imem_rsp_valid = 1'b0;
        n_checks++; if ({valid_next, inst, pc, snpc} !== {1'b1, 32'h0010_0093, 32'h8000_0000, 32'h8000_0004}) begin n_errors++; $display("FAIL basic_first: got v=%b inst=%h pc=%h snpc=%h want 1/00100093/80000000/80000004", valid_next, inst, pc, snpc); end
        tick();
        n_checks++; if ({valid_next, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h8000_0004}) begin n_errors++; $display("FAIL basic_second_req: got v=%b req=%b addr=%h want 0/1/80000004", valid_next, imem_req_valid, imem_addr); end
        fetch_one(32'h0020_0113);
        n_checks++; if ({valid_next, inst, pc, snpc} !== {1'b1, 32'h0020_0113, 32'h8000_0004, 32'h8000_0008}) begin n_errors++; $display("FAIL basic_second: got v=%b inst=%h pc=%h snpc=%h want 1/00200113/80000004/80000008", valid_next, inst, pc, snpc); end
        tick();
        n_checks++; if ({valid_next, imem_addr} !== {1'b0, 32'h8000_0008}) begin n_errors++; $display("FAIL basic_third_req: got v=%b addr=%h want 0/80000008", valid_next, imem_addr); end
    endtask

    task automatic test_backpressure();
        ready_next = 1'b0;
        fetch_one(32'h0030_0193);
        imem_req_ready = 1'b1;   // offered during the stall; must not be taken
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({valid_next, imem_req_valid, inst, pc, snpc} !== {1'b1, 1'b0, 32'h0030_0193, 32'h8000_0008, 32'h8000_000C}) begin n_errors++; $display("FAIL stall_hold[%0d]: got v=%b req=%b inst=%h pc=%h snpc=%h", i, valid_next, imem_req_valid, inst, pc, snpc); end
            tick();
        end
        imem_req_ready = 1'b0;
        ready_next = 1'b1;
        tick();
        n_checks++; if ({valid_next, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h8000_000C}) begin n_errors++; $display("FAIL stall_release: got v=%b req=%b addr=%h want 0/1/8000000c", valid_next, imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        n_checks++; if ({valid_next, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h8000_0100}) begin n_errors++; $display("FAIL redir_wait_drop: got v=%b req=%b addr=%h want 0/1/80000100", valid_next, imem_req_valid, imem_addr); end
        fetch_one(32'h0040_0213);
        n_checks++; if ({valid_next, inst, pc, snpc} !== {1'b1, 32'h0040_0213, 32'h8000_0100, 32'h8000_0104}) begin n_errors++; $display("FAIL redir_wait_next: got v=%b inst=%h pc=%h snpc=%h", valid_next, inst, pc, snpc); end
        tick();
    endtask

    task automatic test_redirect_rsp();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0293;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        n_checks++; if ({valid_next, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h8000_0200}) begin n_errors++; $display("FAIL redir_rsp: got v=%b req=%b addr=%h want 0/1/80000200", valid_next, imem_req_valid, imem_addr); end
        fetch_one(32'h0060_0313);
        n_checks++; if ({valid_next, inst, pc} !== {1'b1, 32'h0060_0313, 32'h8000_0200}) begin n_errors++; $display("FAIL redir_rsp_next: got v=%b inst=%h pc=%h", valid_next, inst, pc); end
        tick();
    endtask

    task automatic test_redirect_accept();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        n_checks++; if ({valid_next, imem_req_valid} !== 2'b00) begin n_errors++; $display("FAIL redir_acc_wait: got v=%b req=%b want 0/0", valid_next, imem_req_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0070_0393;   // belongs to the squashed request
        tick();
        imem_rsp_valid = 1'b0;
        n_checks++; if ({valid_next, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h8000_0300}) begin n_errors++; $display("FAIL redir_acc_drop: got v=%b req=%b addr=%h want 0/1/80000300", valid_next, imem_req_valid, imem_addr); end
        fetch_one(32'h0080_0413);
        n_checks++; if ({valid_next, inst, pc} !== {1'b1, 32'h0080_0413, 32'h8000_0300}) begin n_errors++; $display("FAIL redir_acc_next: got v=%b inst=%h pc=%h", valid_next, inst, pc); end
        tick();
    endtask

    task automatic test_redirect_hold();
        ready_next = 1'b0;
        fetch_one(32'h0090_0493);
        n_checks++; if ({valid_next, pc} !== {1'b1, 32'h8000_0304}) begin n_errors++; $display("FAIL redir_hold_pre: got v=%b pc=%h want 1/80000304", valid_next, pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0403;
        tick();
        redirect_valid = 1'b0;
        ready_next     = 1'b1;
        n_checks++; if ({valid_next, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h8000_0400}) begin n_errors++; $display("FAIL redir_hold: got v=%b req=%b addr=%h want 0/1/80000400", valid_next, imem_req_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        n_checks++; if ({w_req_valid, w_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_errors++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", w_req_valid, w_addr); end
        w_ready     = 1'b0;
        w_req_ready = 1'b1;
        tick();
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b1;
        w_rsp_data  = 32'h00A0_0513;
        tick();
        w_rsp_valid = 1'b0;
        n_checks++; if ({w_valid, w_inst, w_pc, w_snpc} !== {1'b1, 32'h00A0_0513, 32'hFFFF_FFFC, 32'h0000_0000}) begin n_errors++; $display("FAIL wrap_present: got v=%b inst=%h pc=%h snpc=%h", w_valid, w_inst, w_pc, w_snpc); end
        w_ready = 1'b1;
        tick();
        n_checks++; if ({w_valid, w_req_valid, w_addr} !== {1'b0, 1'b1, 32'h0000_0000}) begin n_errors++; $display("FAIL wrap_next_req: got v=%b req=%b addr=%h want 0/1/00000000", w_valid, w_req_valid, w_addr); end
    endtask

    task automatic test_async_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #2;
        reset = 1'b1;   // mid-cycle, away from any edge
        #1;
        n_checks++; if ({imem_req_valid, valid_next, pc, imem_addr} !== {1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000}) begin n_errors++; $display("FAIL async_clear: got req=%b v=%b pc=%h addr=%h", imem_req_valid, valid_next, pc, imem_addr); end
        tick();
        reset          = 1'b0;
        imem_rsp_valid = 1'b1;   // late response from before the reset
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        n_checks++; if ({valid_next, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h8000_0000}) begin n_errors++; $display("FAIL async_stray: got v=%b req=%b addr=%h want 0/1/80000000", valid_next, imem_req_valid, imem_addr); end
        fetch_one(32'h00B0_0593);
        n_checks++; if ({valid_next, inst, pc} !== {1'b1, 32'h00B0_0593, 32'h8000_0000}) begin n_errors++; $display("FAIL async_restart: got v=%b inst=%h pc=%h", valid_next, inst, pc); end
        tick();
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        ready_next     = 1'b0;
        w_req_ready    = 1'b0;
        w_rsp_valid    = 1'b0;
        w_rsp_data     = 32'h0;
        w_ready        = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_redirect_accept();
        test_redirect_hold();
        test_wrap();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ifu_fetch
`default_nettype wire
